// File: rtl/key_poll_master_pkg.sv
// Shared types and bus widths for the key PIO polling master.
package key_poll_master_pkg;

  localparam int unsigned AVM_DATA_W = 32;
  localparam int unsigned AVM_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LAT,
    CAP
  } poll_state_e;

endpackage

// File: rtl/key_poll_master_if.sv
// Avalon-MM read-only link between the polling master and the key PIO slave.
interface key_poll_master_if;
  import key_poll_master_pkg::*;

  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest;
  logic [AVM_DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/key_poll_master_debounce.sv
// Whole-vector debouncer: a new key vector is accepted after DEBOUNCE_N identical samples.
module key_poll_master_debounce #(
  parameter int unsigned KEY_W      = 2,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] sample,
  input  logic             sample_stb,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);

  logic [KEY_W-1:0] last_sample;
  logic [CNT_W-1:0] stable_cnt;
  logic [KEY_W-1:0] next_last;
  logic [CNT_W-1:0] next_cnt;
  logic             accept;

  // Any bit change restarts the count for the whole vector; count saturates.
  always_comb begin
    next_last = last_sample;
    next_cnt  = stable_cnt;
    if (sample != last_sample) begin
      next_last = sample;
      next_cnt  = CNT_W'(1);
    end else if (stable_cnt < CNT_W'(DEBOUNCE_N)) begin
      next_cnt = stable_cnt + CNT_W'(1);
    end
    accept = (next_cnt == CNT_W'(DEBOUNCE_N)) && (next_last != key_state);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sample <= '0;
      stable_cnt  <= '0;
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (sample_stb) begin
        last_sample <= next_last;
        stable_cnt  <= next_cnt;
        if (accept) begin
          key_state   <= next_last;
          key_press   <= next_last & ~key_state;
          key_release <= ~next_last & key_state;
        end
      end
    end
  end

endmodule

// File: rtl/key_poll_master.sv
// Periodically reads the key PIO over Avalon-MM and turns the raw bits into
// debounced key state plus single-cycle press/release events.
module key_poll_master
  import key_poll_master_pkg::*;
#(
  parameter int unsigned          POLL_DIV   = 50000,
  parameter int unsigned          KEY_W      = 2,
  parameter int unsigned          DEBOUNCE_N = 4,
  parameter bit                   ACTIVE_LOW = 1'b1,
  parameter int unsigned          TIMEOUT    = 255,
  parameter logic [AVM_ADDR_W-1:0] PIO_ADDR  = 2'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  key_poll_master_if.master  bus,
  output logic [KEY_W-1:0]   key_state,
  output logic [KEY_W-1:0]   key_press,
  output logic [KEY_W-1:0]   key_release,
  output logic               poll_err
);

  localparam int unsigned TIMER_W = $clog2(POLL_DIV);
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);

  poll_state_e        state;
  logic [TIMER_W-1:0] timer;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [KEY_W-1:0]   raw;
  logic [KEY_W-1:0]   sample;
  logic               sample_stb;
  logic               timer_done;
  logic               unused_readdata;

  assign bus.avm_address = PIO_ADDR;
  assign raw             = bus.avm_readdata[KEY_W-1:0];
  assign unused_readdata = ^bus.avm_readdata[AVM_DATA_W-1:KEY_W];
  assign timer_done      = (timer == TIMER_W'(POLL_DIV - 1));

  // Free-running poll timer keeps the period fixed regardless of bus stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (timer_done) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Read sequencer; a timer expiry outside IDLE simply skips that poll slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.avm_read <= 1'b0;
      wait_cnt     <= '0;
      poll_err     <= 1'b0;
      sample       <= '0;
      sample_stb   <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (timer_done) begin
            state        <= REQ;
            bus.avm_read <= 1'b1;
            wait_cnt     <= '0;
          end
        end
        REQ: begin
          if (!bus.avm_waitrequest) begin
            state        <= LAT;
            bus.avm_read <= 1'b0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state        <= IDLE;
            bus.avm_read <= 1'b0;
            poll_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        LAT: begin
          sample     <= ACTIVE_LOW ? ~raw : raw;
          sample_stb <= 1'b1;
          state      <= CAP;
        end
        CAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  key_poll_master_debounce #(
    .KEY_W      (KEY_W),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample),
    .sample_stb  (sample_stb),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release)
  );

endmodule

// File: tb/tb_key_poll_master.sv
// Scoreboard bench: a latency-1 Avalon slave model with programmable stalls feeds a
// sample-history debounce model; an independent monitor checks bus and key outputs.
module tb_key_poll_master;
  import key_poll_master_pkg::*;

  localparam int unsigned POLL_DIV = 8;
  localparam int unsigned KEY_W    = 2;
  localparam int unsigned DB_N     = 4;
  localparam int unsigned TIMEOUT  = 16;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] state;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_poll_master_if bus ();
  logic [KEY_W-1:0] key_state, key_press, key_release;
  logic             poll_err;

  key_poll_master #(
    .POLL_DIV   (POLL_DIV),
    .KEY_W      (KEY_W),
    .DEBOUNCE_N (DB_N),
    .ACTIVE_LOW (1'b1),
    .TIMEOUT    (TIMEOUT),
    .PIO_ADDR   (2'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .poll_err    (poll_err)
  );

  // Cycles since reset release
  int cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // Shared between processes (each written by exactly one side)
  exp_t       exp_q[$];
  logic [1:0] raw_q[$];
  int         stall_q[$];
  logic [1:0] idle_raw;
  int         cur_stall;
  int         reads_done;
  bit         done_flag, final_done;

  // ---------------- slave + reference model ----------------
  bit         s_txn, lat;
  int         stall_left;
  logic [1:0] raw_cur, s, m_state;
  logic [1:0] hist[$];
  bit         stable;
  logic [31:0] rd;

  initial begin
    reads_done = 0;
    cur_stall  = 0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
  end

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      s_txn = 0; lat = 0; stall_left = 0;
      hist.delete();
      m_state = '0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = '0;
    end else begin
      rd = $urandom;
      if (lat) rd[1:0] = raw_cur;
      bus.avm_readdata = rd;
      lat = 0;
      if (bus.avm_read) begin
        if (!s_txn) begin
          s_txn      = 1;
          cur_stall  = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
          stall_left = cur_stall;
        end
        if (stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          s_txn   = 0;
          lat     = 1;
          raw_cur = (raw_q.size() > 0) ? raw_q.pop_front() : idle_raw;
          // Key is pressed when its raw bit is low; accept after DB_N equal samples
          s = ~raw_cur;
          hist.push_back(s);
          if (hist.size() > int'(DB_N)) void'(hist.pop_front());
          stable = (hist.size() == int'(DB_N));
          foreach (hist[i]) if (hist[i] != s) stable = 0;
          if (stable && s != m_state) begin
            exp_q.push_back('{cyc + 3, s & ~m_state, ~s & m_state, s});
            m_state = s;
          end
          reads_done++;
        end
      end else begin
        s_txn = 0;
        bus.avm_waitrequest = 1'($urandom);
      end
    end
  end

  // ---------------- monitor / checker ----------------
  int         vec_cnt, err_cnt;
  bit         m_txn, err_exp;
  int         rd_len, lat_chk;
  logic [1:0] mon_state;
  exp_t       e;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; final_done = 0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", int'({bus.avm_read, key_state, key_press, key_release, poll_err}), 0);
      m_txn = 0; rd_len = 0; lat_chk = 0; err_exp = 0; mon_state = '0;
    end else begin
      if (done_flag && !final_done) begin
        chk("pending_events", exp_q.size(), 0);
        chk("final_key_state", int'(key_state), int'(mon_state));
        final_done = 1;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (key_press != 0 || key_release != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", int'({key_press, key_release}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("key_press", int'(key_press), int'(e.press));
          chk("key_release", int'(key_release), int'(e.rel));
          chk("key_state", int'(key_state), int'(e.state));
          mon_state = e.state;
        end
      end
      if (lat_chk > 0) begin
        chk("read_low_after_accept", int'(bus.avm_read), 0);
        lat_chk--;
      end else if (bus.avm_read) begin
        if (!m_txn) begin
          m_txn  = 1;
          rd_len = 1;
          chk("poll_slot", cyc % int'(POLL_DIV), 0);
          chk("avm_address", int'(bus.avm_address), 0);
        end else begin
          rd_len++;
        end
        if (!bus.avm_waitrequest) begin
          chk("read_len", rd_len, cur_stall + 1);
          chk("poll_err", int'(poll_err), int'(err_exp));
          m_txn   = 0;
          lat_chk = 2;
        end
      end else if (m_txn) begin
        chk("read_len_at_drop", rd_len, int'(TIMEOUT));
        chk("poll_err_set", int'(poll_err), 1);
        chk("key_state_kept", int'(key_state), int'(mon_state));
        err_exp = 1;
        m_txn   = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_reads(input int n);
    int target;
    target = reads_done + n;
    for (int i = 0; i < n * 48; i++) begin
      @(negedge clk);
      if (reads_done >= target) return;
    end
    $display("FAIL wait_reads: got %0d reads expected %0d", reads_done, target);
    $fatal(1, "read budget expired");
  endtask

  task automatic wait_read_rise();
    for (int i = 0; i < 4 * int'(POLL_DIV); i++) begin
      @(posedge clk);
      #1;
      if (bus.avm_read) return;
    end
    $display("FAIL read_start: got avm_read=0 expected 1");
    $fatal(1, "no read issued");
  endtask

  logic [1:0] bounce[9];
  logic [1:0] cur;
  int         r;

  initial begin
    done_flag = 0;
    idle_raw  = 2'b11;
    bounce    = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted while a read is pending
    wait_read_rise();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Clean press of key 0
    raw_q.push_back(2'b11);
    repeat (5) raw_q.push_back(2'b10);
    idle_raw = 2'b10;
    wait_reads(8);

    // Release, then a bouncing press
    repeat (4) raw_q.push_back(2'b11);
    foreach (bounce[i]) raw_q.push_back(bounce[i]);
    wait_reads(14);

    // Stalled reads, including one just below the timeout
    stall_q.push_back(5);
    wait_reads(2);
    stall_q.push_back(int'(TIMEOUT) - 1);
    wait_reads(2);

    // Stuck waitrequest
    stall_q.push_back(1000);
    wait_reads(2);

    // Simultaneous press on key 1 and release on key 0
    repeat (4) raw_q.push_back(2'b01);
    idle_raw = 2'b01;
    wait_reads(6);

    // Randomized raw levels and stalls
    cur = 2'b01;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) cur = 2'($urandom);
      raw_q.push_back(cur);
      r = $urandom_range(15);
      stall_q.push_back((r == 0) ? 1000 : r % 4);
    end
    idle_raw = cur;
    wait_reads(60);
    repeat (20) @(negedge clk);

    done_flag = 1;
    for (int i = 0; i < 10 && !final_done; i++) @(negedge clk);
    if (!final_done) begin
      $display("FAIL final_check: got 0 expected 1");
      $fatal(1, "final check not reached");
    end

    // Reset after errors and key activity
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
